// File: rtl/rom_stream_reader.sv
// Burst reader for a 32x4 synchronous ROM: walks a wrapping address range and
// re-emits the read data as a valid/ready stream through a 2-entry skid buffer.
module rom_stream_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  total;
  logic [LEN_W-1:0]  captured;
  logic              inflight;

  logic [DATA_W-1:0] buf_data [2];
  logic              buf_last [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic [2:0]        occupancy;

  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign busy      = (state != IDLE);

  assign pop    = out_valid && out_ready;
  assign push   = inflight;
  assign accept = (state == IDLE) && start && (length != '0);

  // Slots that will be held after this edge if nothing new is issued: a word
  // already in flight still needs a buffer entry when it lands next cycle.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and a latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        issue = (remaining != '0) && (occupancy < 3'd2);
        if (issue && remaining == LEN_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        done = pop && buf_last[rd_ptr];
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_en   = issue;
  assign rom_addr = issue ? addr : last_addr;

  // NOTE: state elements use non-blocking assignments so every register sees
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      total     <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        addr      <= start_addr;
        remaining <= length;
        total     <= length;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        last_addr <= addr;
      end
    end
  end

  // NOTE: the two buffer entries are reset too; they drive out_data directly,
  // which must read 0 after reset rather than leftover words of an aborted burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      captured    <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= rom_data;
        buf_last[wr_ptr] <= (captured == total - LEN_W'(1));
        wr_ptr           <= ~wr_ptr;
        captured         <= captured + LEN_W'(1);
      end
      if (accept) captured <= '0;
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  overflow_never: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: a ROM model feeds the DUT and an
// expected-word queue derived from (start_addr + i) mod 32 scores the stream.
module tb_rom_stream_reader;

  localparam logic [3:0] ROM_T [32] = '{
    4'h6, 4'hA, 4'hE, 4'h6, 4'hF, 4'hA, 4'hC, 4'h3,
    4'h9, 4'h1, 4'h5, 4'h7, 4'hB, 4'hD, 4'hC, 4'h6,
    4'h0, 4'h0, 4'h2, 4'h8, 4'h4, 4'hE, 4'h1, 4'h9,
    4'h3, 4'hB, 4'h5, 4'hD, 4'h7, 4'hF, 4'h2, 4'h0
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] start_addr = '0;
  logic [5:0] length = '0;
  logic       rom_en;
  logic [4:0] rom_addr;
  logic [3:0] rom_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  rom_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= ROM_T[rom_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_rom_en"},    rom_en,    0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  // mode 0: ready held high; mode 1: ready low through cycle 'hold';
  // mode 2: random ready plus a stray start while busy.
  task automatic run_burst(input logic [4:0] sa, input logic [5:0] len,
                           input int mode, input int hold);
    logic [3:0] exp_q [$];
    logic [4:0] addr_q [$];
    int cyc = 1;
    int outstanding = 0;
    int got = 0;
    int first_valid = -1;
    int done_cyc = -1;
    int issues = 0;
    bit handshake;
    for (int i = 0; i < int'(len); i++) begin
      addr_q.push_back(5'((int'(sa) + i) % 32));
      exp_q.push_back(ROM_T[(int'(sa) + i) % 32]);
    end

    start = 1'b1;
    start_addr = sa;
    length = len;
    out_ready = (mode == 0);
    next_cycle();
    start = 1'b0;

    while (done_cyc < 0 && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 :
                  (mode == 1) ? (cyc > hold) : 1'($urandom_range(0, 1));
      start = (mode == 2 && cyc == 2);
      if (start) begin
        start_addr = 5'($urandom);
        length = 6'($urandom_range(1, 32));
      end
      @(negedge clk);
      check("busy_in_burst", busy, 1);
      if (rom_en) begin
        if (addr_q.size() == 0) check("extra_rom_en", 1, 0);
        else check("rom_addr", rom_addr, addr_q.pop_front());
        outstanding++;
        issues++;
      end
      if (mode == 1 && cyc == hold) check("issues_before_release", issues, 2);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid) begin
        if (exp_q.size() == 0) check("extra_out_valid", 1, 0);
        else check("out_data", out_data, exp_q[0]);
      end
      handshake = out_valid && out_ready;
      if (handshake && exp_q.size() != 0) begin
        check("out_last", out_last, (got == int'(len) - 1));
        check("done", done, (got == int'(len) - 1));
        void'(exp_q.pop_front());
        outstanding--;
        got++;
        if (done) done_cyc = cyc;
      end else begin
        check("done_idle", done, 0);
      end
      check("outstanding_le_2", (outstanding <= 2), 1);
      next_cycle();
      cyc++;
    end
    start = 1'b0;

    if (done_cyc < 0) check("timeout_no_done", 0, 1);
    check("words_delivered", got, int'(len));
    check("addrs_issued", issues, int'(len));
    if (mode == 0) begin
      check("first_valid_cycle", first_valid, 3);
      check("done_cycle", done_cyc, int'(len) + 2);
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("valid_after_done", out_valid, 0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    check_all_zero("reset");
    next_cycle();

    run_burst(5'd0,  6'd4, 0, 0);
    run_burst(5'd14, 6'd4, 0, 0);
    run_burst(5'd31, 6'd2, 0, 0);
    run_burst(5'd4,  6'd3, 1, 10);
    run_burst(5'd0,  6'd32, 2, 0);
    for (int k = 0; k < 4; k++)
      run_burst(5'($urandom), 6'($urandom_range(1, 32)), 2, 0);

    // reset in the third cycle of a burst abandons it silently
    start = 1'b1;
    start_addr = 5'd0;
    length = 6'd8;
    out_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    check_all_zero("mid_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_rom_en", rom_en, 0);
      next_cycle();
    end
    run_burst(5'd0, 6'd4, 0, 0);

    // zero length is ignored
    start = 1'b1;
    start_addr = 5'd9;
    length = 6'd0;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("len0_rom_en", rom_en, 0);
      check("len0_busy", busy, 0);
      next_cycle();
    end
    run_burst(5'd28, 6'd6, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
